// File: rtl/music_pkg.sv
// Shared definitions for the MUSIC front end and the EVD block.
//   MAT_DIM / EVD_W : matrix dimension and EVD word width, shared with the EVD
//   NUM_PAIRS       : number of unique (i,j), i<=j, entries of a symmetric 4x4 matrix
//   state_e         : covariance builder FSM encoding
//   pair_row/col    : pair index -> (i,j) table, order (0,0)(0,1)(0,2)(0,3)(1,1)(1,2)(1,3)(2,2)(2,3)(3,3)
//   mat_idx         : row-major flat index 4r+c
package music_pkg;

    localparam int MAT_DIM   = 4;
    localparam int NUM_PAIRS = 10;
    localparam int EVD_W     = 32;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_MAC     = 3'd1,
        ST_SCALE   = 3'd2,
        ST_HANDOFF = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    function automatic logic [1:0] pair_row(input logic [3:0] p);
        case (p)
            4'd0, 4'd1, 4'd2, 4'd3: return 2'd0;
            4'd4, 4'd5, 4'd6:       return 2'd1;
            4'd7, 4'd8:             return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] pair_col(input logic [3:0] p);
        case (p)
            4'd0:             return 2'd0;
            4'd1, 4'd4:       return 2'd1;
            4'd2, 4'd5, 4'd7: return 2'd2;
            default:          return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] mat_idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

endpackage

// File: rtl/cov_matrix_builder_if.sv
// Snapshot input / EVD matrix handoff bundle of the covariance builder.
//   snap_valid, snap_ready, x0..x3 : snapshot handshake and signed channel samples
//   data_available, output_available : matrix valid / EVD completion pulse
//   A[16]      : signed row-major covariance, A[4r+c]
//   snap_cnt   : snapshots accumulated in the current matrix
//   err_timeout: sticky EVD no-response flag
// slave = builder side, master = snapshot source + EVD side.
interface cov_matrix_builder_if #(
    parameter int SAMPLE_W    = 16,
    parameter int N_SNAP_LOG2 = 6
);
    import music_pkg::*;

    logic                       snap_valid;
    logic                       snap_ready;
    logic signed [SAMPLE_W-1:0] x0;
    logic signed [SAMPLE_W-1:0] x1;
    logic signed [SAMPLE_W-1:0] x2;
    logic signed [SAMPLE_W-1:0] x3;
    logic                       data_available;
    logic                       output_available;
    logic signed [EVD_W-1:0]    A [MAT_DIM*MAT_DIM];
    logic [N_SNAP_LOG2-1:0]     snap_cnt;
    logic                       err_timeout;

    modport slave (
        input  snap_valid, x0, x1, x2, x3, output_available,
        output snap_ready, data_available, A, snap_cnt, err_timeout
    );

    modport master (
        output snap_valid, x0, x1, x2, x3, output_available,
        input  snap_ready, data_available, A, snap_cnt, err_timeout
    );

endinterface

// File: rtl/cov_matrix_builder_mac.sv
// Accumulator bank for the 10 unique covariance terms.
//   clk, rst_n : clock, async active-low reset (clears all accumulators)
//   mac_en_i   : acc[idx_i] += a_i * b_i
//   clr_i      : acc[idx_i] <= 0 (ignored when mac_en_i is set)
//   idx_i      : pair index 0..9
//   a_i, b_i   : signed samples feeding the single multiplier
//   v_o        : acc[idx_i] averaged, scaled, saturated to SAT_W and sign-extended to EVD_W
module cov_mac_bank
    import music_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int N_SNAP_LOG2 = 6,
    parameter int SCALE_SHIFT = 0,
    parameter int SAT_W       = 22
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mac_en_i,
    input  logic                       clr_i,
    input  logic [3:0]                 idx_i,
    input  logic signed [SAMPLE_W-1:0] a_i,
    input  logic signed [SAMPLE_W-1:0] b_i,
    output logic signed [EVD_W-1:0]    v_o
);
    // Width covers 2^N_SNAP_LOG2 worst-case products, so the sum cannot wrap.
    localparam int ACC_W = 2*SAMPLE_W + N_SNAP_LOG2;
    localparam int SHIFT = N_SNAP_LOG2 + SCALE_SHIFT;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(SAT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(SAT_W-1)));

    logic signed [ACC_W-1:0]      acc_q [NUM_PAIRS];
    logic signed [2*SAMPLE_W-1:0] prod;
    logic signed [ACC_W-1:0]      acc_d;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [ACC_W-1:0]      sat;

    assign prod    = a_i * b_i;
    assign acc_d   = acc_q[idx_i] + ACC_W'(prod);
    assign shifted = acc_q[idx_i] >>> SHIFT;

    always_comb begin
        sat = shifted;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN;
        end
    end

    assign v_o = EVD_W'(sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PAIRS; k++) acc_q[k] <= '0;
        end else if (mac_en_i) begin
            acc_q[idx_i] <= acc_d;
        end else if (clr_i) begin
            acc_q[idx_i] <= '0;
        end
    end

endmodule

// File: rtl/cov_matrix_builder.sv
// Covariance matrix builder: accumulates R = sum(x*x^T) over 2^N_SNAP_LOG2
// 4-channel snapshots, scales/saturates it into the EVD range and holds it
// for the EVD until output_available (or a timeout).
//   clk, rst_n : clock, async active-low reset
//   bus        : cov_matrix_builder_if.slave (snapshot handshake, A0..A15, EVD handshake, status)
//
// state      | meaning
// -----------+----------------------------------------------------------
// COLLECT    | snap_ready high, waiting for a snapshot
// MAC        | 10 cycles, one pair product accumulated per cycle
// SCALE      | 10 cycles, one pair scaled into A (mirrored), acc cleared
// HANDOFF    | data_available high, A frozen, waiting for EVD / timeout
// RELEASE    | data_available low for RELEASE_CYC cycles before COLLECT
module cov_matrix_builder
    import music_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int N_SNAP_LOG2 = 6,
    parameter int SCALE_SHIFT = 0,
    parameter int SAT_W       = 22,
    parameter int TIMEOUT_CYC = 1023,
    parameter int RELEASE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    cov_matrix_builder_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [3:0] LAST_PAIR = 4'(NUM_PAIRS - 1);

    state_e                     state_q;
    logic [3:0]                 pair_q;
    logic signed [SAMPLE_W-1:0] x_q [MAT_DIM];
    logic signed [EVD_W-1:0]    a_q [MAT_DIM*MAT_DIM];
    logic [N_SNAP_LOG2-1:0]     snap_cnt_q;
    logic                       rdy_q;
    logic                       da_q;
    logic                       err_q;
    logic [TMR_W-1:0]           tmr_q;
    logic [REL_W-1:0]           rel_q;
    logic signed [EVD_W-1:0]    scaled;

    cov_mac_bank #(
        .SAMPLE_W   (SAMPLE_W),
        .N_SNAP_LOG2(N_SNAP_LOG2),
        .SCALE_SHIFT(SCALE_SHIFT),
        .SAT_W      (SAT_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .mac_en_i(state_q == ST_MAC),
        .clr_i   (state_q == ST_SCALE),
        .idx_i   (pair_q),
        .a_i     (x_q[pair_row(pair_q)]),
        .b_i     (x_q[pair_col(pair_q)]),
        .v_o     (scaled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            pair_q     <= '0;
            snap_cnt_q <= '0;
            rdy_q      <= 1'b0;
            da_q       <= 1'b0;
            err_q      <= 1'b0;
            tmr_q      <= '0;
            rel_q      <= '0;
            for (int k = 0; k < MAT_DIM; k++) x_q[k] <= '0;
            for (int k = 0; k < MAT_DIM*MAT_DIM; k++) a_q[k] <= '0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (bus.snap_valid && rdy_q) begin
                        x_q[0]  <= bus.x0;
                        x_q[1]  <= bus.x1;
                        x_q[2]  <= bus.x2;
                        x_q[3]  <= bus.x3;
                        rdy_q   <= 1'b0;
                        pair_q  <= '0;
                        state_q <= ST_MAC;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                ST_MAC: begin
                    if (pair_q == LAST_PAIR) begin
                        pair_q     <= '0;
                        snap_cnt_q <= snap_cnt_q + 1'b1;
                        if (snap_cnt_q == '1) begin
                            state_q <= ST_SCALE;
                        end else begin
                            // Ready rises with the state change so a held
                            // snap_valid transfers every 11 cycles.
                            state_q <= ST_COLLECT;
                            rdy_q   <= 1'b1;
                        end
                    end else begin
                        pair_q <= pair_q + 1'b1;
                    end
                end
                ST_SCALE: begin
                    a_q[mat_idx(pair_row(pair_q), pair_col(pair_q))] <= scaled;
                    a_q[mat_idx(pair_col(pair_q), pair_row(pair_q))] <= scaled;
                    if (pair_q == LAST_PAIR) begin
                        pair_q     <= '0;
                        snap_cnt_q <= '0;
                        da_q       <= 1'b1;
                        tmr_q      <= TMR_W'(TIMEOUT_CYC - 1);
                        state_q    <= ST_HANDOFF;
                    end else begin
                        pair_q <= pair_q + 1'b1;
                    end
                end
                ST_HANDOFF: begin
                    // Completion wins over a timeout expiring in the same cycle.
                    if (bus.output_available || tmr_q == '0) begin
                        if (!bus.output_available) err_q <= 1'b1;
                        da_q    <= 1'b0;
                        rel_q   <= REL_W'(RELEASE_CYC - 1);
                        state_q <= ST_RELEASE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (rel_q == '0) begin
                        state_q <= ST_COLLECT;
                        rdy_q   <= 1'b1;
                    end else begin
                        rel_q <= rel_q - 1'b1;
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign bus.snap_ready     = rdy_q;
    assign bus.data_available = da_q;
    assign bus.A              = a_q;
    assign bus.snap_cnt       = snap_cnt_q;
    assign bus.err_timeout    = err_q;

endmodule

// File: tb/tb_cov_matrix_builder.sv
// Directed bench for cov_matrix_builder (N_SNAP_LOG2=2, SCALE_SHIFT=0).
// dut uses TIMEOUT_CYC=1023; dut_t uses TIMEOUT_CYC=50 for the timeout scenarios.
module tb_cov_matrix_builder;
    import music_pkg::*;

    localparam int SW = 16;
    localparam int NL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    cov_matrix_builder_if #(.SAMPLE_W(SW), .N_SNAP_LOG2(NL)) b ();
    cov_matrix_builder_if #(.SAMPLE_W(SW), .N_SNAP_LOG2(NL)) bt ();

    cov_matrix_builder #(
        .SAMPLE_W(SW), .N_SNAP_LOG2(NL), .SCALE_SHIFT(0), .SAT_W(22),
        .TIMEOUT_CYC(1023), .RELEASE_CYC(2)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    cov_matrix_builder #(
        .SAMPLE_W(SW), .N_SNAP_LOG2(NL), .SCALE_SHIFT(0), .SAT_W(22),
        .TIMEOUT_CYC(50), .RELEASE_CYC(2)
    ) dut_t (.clk(clk), .rst_n(rst_n), .bus(bt));

    int exp1 [16] = '{10000, -5000, 0, 2500,
                      -5000, 2500, 0, -1250,
                      0, 0, 0, 0,
                      2500, -1250, 0, 625};
    int exp2 [16] = '{2097151, -2097152, 0, 0,
                      -2097152, 2097151, 0, 0,
                      0, 0, 0, 0,
                      0, 0, 0, 0};

    // Drives one snapshot; returns (at the following negedge) the edge index of the transfer.
    task automatic send(input bit to_t, input int v0, input int v1, input int v2, input int v3,
                        output int t_edge);
        int budget;
        budget = 200;
        @(negedge clk);
        if (to_t) begin
            bt.snap_valid = 1'b1; bt.x0 = SW'(v0); bt.x1 = SW'(v1); bt.x2 = SW'(v2); bt.x3 = SW'(v3);
        end else begin
            b.snap_valid = 1'b1; b.x0 = SW'(v0); b.x1 = SW'(v1); b.x2 = SW'(v2); b.x3 = SW'(v3);
        end
        while (((to_t ? bt.snap_ready : b.snap_ready) !== 1'b1) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_errors++;
            $display("FAIL send_ready_wait: snap_ready never rose within 200 cycles (to_t=%0d)", to_t);
        end
        @(posedge clk);
        @(negedge clk);
        t_edge = cyc;
        b.snap_valid = 1'b0;
        bt.snap_valid = 1'b0;
    endtask

    task automatic wait_da(input bit to_t, input logic lvl, input int budget,
                           output int e, output bit ok);
        ok = 1'b0;
        e = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((to_t ? bt.data_available : b.data_available) === lvl) begin
                ok = 1'b1;
                e = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int nz;
        #12;
        nz = 0;
        for (int k = 0; k < 16; k++) if (b.A[k] !== 32'sd0) nz++;
        n_checks++;
        if (b.snap_ready !== 1'b0 || b.data_available !== 1'b0 || b.err_timeout !== 1'b0 ||
            b.snap_cnt !== 2'd0 || nz != 0) begin
            n_errors++;
            $display("FAIL reset_outputs: ready=%b da=%b err=%b cnt=%0d nonzeroA=%0d, required all 0",
                     b.snap_ready, b.data_available, b.err_timeout, b.snap_cnt, nz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (b.snap_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready_before_edge: got %b required 0", b.snap_ready);
        end
        @(negedge clk);
        n_checks++;
        if (b.snap_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready_after_edge: got %b required 1", b.snap_ready);
        end
    endtask

    task automatic test_basic();
        int t, e;
        bit ok;
        send(0, 100, -50, 0, 25, t);
        send(0, 100, -50, 0, 25, t);
        // EVD completion pulse while collecting must be ignored.
        b.output_available = 1'b1;
        @(negedge clk);
        b.output_available = 1'b0;
        send(0, 100, -50, 0, 25, t);
        send(0, 100, -50, 0, 25, t);
        wait_da(0, 1'b1, 60, e, ok);
        n_checks++;
        if (!ok || e != t + 20) begin
            n_errors++;
            $display("FAIL basic_latency: data_available rose after edge %0d, required edge %0d", e, t + 20);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (b.A[k] !== exp1[k]) begin
                n_errors++;
                $display("FAIL basic_A%0d: got %0d required %0d", k, b.A[k], exp1[k]);
            end
        end
        n_checks++;
        if (b.snap_cnt !== 2'd0 || b.snap_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_handoff_status: cnt=%0d ready=%b required 0/0", b.snap_cnt, b.snap_ready);
        end
        b.output_available = 1'b1;
        @(negedge clk);
        b.output_available = 1'b0;
        n_checks++;
        if (b.data_available !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_release: data_available=%b required 0", b.data_available);
        end
    endtask

    task automatic test_saturation_hold();
        int t, e, bad;
        bit ok;
        for (int s = 0; s < 4; s++) send(0, 32767, -32768, 0, 0, t);
        wait_da(0, 1'b1, 60, e, ok);
        n_checks++;
        if (!ok || e != t + 20) begin
            n_errors++;
            $display("FAIL sat_latency: rose after edge %0d required %0d", e, t + 20);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (b.A[k] !== exp2[k]) begin
                n_errors++;
                $display("FAIL sat_A%0d: got %0d required %0d", k, b.A[k], exp2[k]);
            end
        end
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (b.data_available !== 1'b1) bad++;
            for (int k = 0; k < 16; k++) if (b.A[k] !== exp2[k]) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL hold_200: %0d deviations from held matrix, required 0", bad);
        end
        b.output_available = 1'b1;
        @(negedge clk);
        b.output_available = 1'b0;
        n_checks++;
        if (b.data_available !== 1'b0 || b.snap_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_release: da=%b ready=%b required 0/0", b.data_available, b.snap_ready);
        end
        @(negedge clk);
        n_checks++;
        if (b.snap_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL release_cycle1: ready=%b required 0", b.snap_ready);
        end
        @(negedge clk);
        n_checks++;
        if (b.snap_ready !== 1'b1 || b.A[0] !== 32'sd2097151) begin
            n_errors++;
            $display("FAIL release_cycle2: ready=%b A0=%0d required 1/2097151", b.snap_ready, b.A[0]);
        end
    endtask

    task automatic test_timeout();
        int t, h, e;
        bit ok;
        // Matrix 1: completion arrives on the very cycle the timer expires.
        for (int s = 0; s < 4; s++) send(1, 1, 2, 3, 4, t);
        wait_da(1, 1'b1, 60, h, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL to_m1_rise: data_available never rose");
        end
        while (cyc < h + 49) @(negedge clk);
        n_checks++;
        if (bt.data_available !== 1'b1) begin
            n_errors++;
            $display("FAIL to_early: data_available=%b at edge %0d required 1", bt.data_available, cyc);
        end
        bt.output_available = 1'b1;
        @(negedge clk);
        bt.output_available = 1'b0;
        n_checks++;
        if (bt.data_available !== 1'b0 || bt.err_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL to_same_cycle: da=%b err=%b required 0/0", bt.data_available, bt.err_timeout);
        end
        // Matrix 2: EVD silent.
        for (int s = 0; s < 4; s++) send(1, 1, 2, 3, 4, t);
        wait_da(1, 1'b1, 60, h, ok);
        wait_da(1, 1'b0, 100, e, ok);
        n_checks++;
        if (!ok || e != h + 50) begin
            n_errors++;
            $display("FAIL to_fall: fell after edge %0d required %0d", e, h + 50);
        end
        n_checks++;
        if (bt.err_timeout !== 1'b1) begin
            n_errors++;
            $display("FAIL to_err_set: err_timeout=%b required 1", bt.err_timeout);
        end
        // Matrix 3: flag stays sticky.
        for (int s = 0; s < 4; s++) send(1, 1, 2, 3, 4, t);
        wait_da(1, 1'b1, 60, h, ok);
        bt.output_available = 1'b1;
        @(negedge clk);
        bt.output_available = 1'b0;
        n_checks++;
        if (!ok || bt.err_timeout !== 1'b1 || bt.data_available !== 1'b0) begin
            n_errors++;
            $display("FAIL to_err_sticky: ok=%0d err=%b da=%b required 1/1/0", ok, bt.err_timeout, bt.data_available);
        end
    endtask

    task automatic test_back_to_back();
        int tr[$];
        int cnt_seen[$];
        int exp_cnt [4] = '{1, 2, 3, 0};
        bit released;
        released = 1'b0;
        @(negedge clk);
        b.snap_valid = 1'b1;
        b.x0 = 16'sd1; b.x1 = 16'sd0; b.x2 = 16'sd0; b.x3 = 16'sd0;
        for (int i = 0; i < 150; i++) begin
            if (tr.size() >= 1 && cyc == tr[tr.size()-1] + 10) cnt_seen.push_back(int'(b.snap_cnt));
            if (b.snap_ready === 1'b1) tr.push_back(cyc + 1);
            if (tr.size() == 5) break;
            b.output_available = 1'b0;
            if (!released && b.data_available === 1'b1) begin
                b.output_available = 1'b1;
                released = 1'b1;
            end
            @(negedge clk);
        end
        b.snap_valid = 1'b0;
        b.output_available = 1'b0;
        n_checks++;
        if (tr.size() != 5) begin
            n_errors++;
            $display("FAIL b2b_count: %0d transfers seen required 5", tr.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (tr[k] - tr[k-1] != 11) begin
                    n_errors++;
                    $display("FAIL b2b_gap%0d: %0d cycles required 11", k, tr[k] - tr[k-1]);
                end
            end
            n_checks++;
            if (tr[4] - tr[3] != 24) begin
                n_errors++;
                $display("FAIL b2b_gap_handoff: %0d cycles required 24", tr[4] - tr[3]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= cnt_seen.size() || cnt_seen[k] != exp_cnt[k]) begin
                n_errors++;
                $display("FAIL b2b_snap_cnt%0d: got %0d required %0d", k,
                         (k < cnt_seen.size()) ? cnt_seen[k] : -1, exp_cnt[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, e;
        bit ok;
        send(0, 50, -3, 9, 11, t);
        send(0, 50, -3, 9, 11, t);
        send(0, 50, -3, 9, 11, t);
        repeat (3) @(negedge clk);
        n_checks++;
        if (b.snap_cnt !== 2'd2 || b.A[0] !== 32'sd1) begin
            n_errors++;
            $display("FAIL mid_pre: cnt=%0d A0=%0d required 2/1", b.snap_cnt, b.A[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (b.snap_ready !== 1'b0 || b.data_available !== 1'b0 || b.snap_cnt !== 2'd0 ||
            b.A[0] !== 32'sd0 || b.err_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_async_reset: ready=%b da=%b cnt=%0d A0=%0d err=%b required all 0",
                     b.snap_ready, b.data_available, b.snap_cnt, b.A[0], b.err_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) send(0, 1, 1, 1, 1, t);
        wait_da(0, 1'b1, 60, e, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL mid_rise: data_available never rose");
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (b.A[k] !== 32'sd1) begin
                n_errors++;
                $display("FAIL mid_A%0d: got %0d required 1", k, b.A[k]);
            end
        end
        b.output_available = 1'b1;
        @(negedge clk);
        b.output_available = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        b.snap_valid = 1'b0; b.output_available = 1'b0;
        b.x0 = '0; b.x1 = '0; b.x2 = '0; b.x3 = '0;
        bt.snap_valid = 1'b0; bt.output_available = 1'b0;
        bt.x0 = '0; bt.x1 = '0; bt.x2 = '0; bt.x3 = '0;
        test_reset();
        test_basic();
        test_saturation_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
